// File: rtl/phase_seq_if.sv
// Opcode encodings shared by the sequencer and its datapath, plus the bundle
// of control/status signals between them.
package phase_seq_pkg;
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYS    = 7'b1110011
    } opcode_t;
endpackage

interface phase_seq_if #(
    parameter int BW = 1
);
    phase_seq_pkg::opcode_t opcode;
    phase_seq_pkg::opcode_t next_opcode;
    logic          branch_taken;
    logic          forward_taken;
    logic          shift_busy;
    logic          mem_ready;
    logic          resume;
    logic [1:0]    phase;
    logic [BW-1:0] beat;
    logic          first_beat;
    logic          last_beat;
    logic          boot;
    logic          halted;
    logic          stall;
    logic          rf_wren;
    logic          mem_rden;
    logic          mem_wren;
    logic          trap;

    // master is the sequencer, slave is the datapath/decoder side
    modport master (
        input  opcode, next_opcode, branch_taken, forward_taken,
               shift_busy, mem_ready, resume,
        output phase, beat, first_beat, last_beat, boot, halted, stall,
               rf_wren, mem_rden, mem_wren, trap
    );
    modport slave (
        output opcode, next_opcode, branch_taken, forward_taken,
               shift_busy, mem_ready, resume,
        input  phase, beat, first_beat, last_beat, boot, halted, stall,
               rf_wren, mem_rden, mem_wren, trap
    );
endinterface

// File: rtl/phase_seq.sv
// Phase/beat sequencer for the bit-sliced multi-cycle RV32 core: walks each
// instruction through phases 0-3, one SLICE-wide beat per cycle.
module phase_seq
    import phase_seq_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SLICE        = 1,
    parameter bit HALT_ON_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    phase_seq_if.master bus
);
    localparam int            BEATS = XLEN / SLICE;
    localparam int            BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST  = BW'(BEATS - 1);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          firstBeat_q, firstBeat_d;

    logic       isBoot, isRun, isHalt, lastBeat;
    logic       succEnd, succHalt, succRepeat, finalPhase;
    logic [1:0] succPhase, endPhase;
    logic       rfWren, memRden, memWren, memWait, complete;

    function automatic logic [1:0] fcPhase(opcode_t op);
        case (op)
            OP_IMM, OP_AUIPC:          fcPhase = 2'd2;
            OP_OP, OP_LOAD, OP_STORE:  fcPhase = 2'd1;
            default:                   fcPhase = 2'd0;
        endcase
    endfunction

    assign isBoot   = (state_q == S_BOOT);
    assign isRun    = (state_q == S_RUN);
    assign isHalt   = (state_q == S_HALT);
    assign lastBeat = (beat_q == LAST);
    assign endPhase = bus.forward_taken ? fcPhase(bus.next_opcode) : 2'd0;

    always_comb begin
        succPhase  = 2'd2;
        succEnd    = 1'b0;
        succHalt   = 1'b0;
        succRepeat = 1'b0;
        case (phase_q)
            2'd0: begin
                case (bus.opcode)
                    OP_OP, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: succPhase = 2'd1;
                    OP_SYS:  succHalt = HALT_ON_TRAP;
                    default: succPhase = 2'd2;
                endcase
            end
            2'd1: succPhase = (bus.opcode == OP_STORE) ? 2'd3 : 2'd2;
            2'd2: begin
                if (bus.opcode == OP_LOAD) begin
                    succPhase = 2'd3;
                end else if (bus.opcode == OP_BRANCH && bus.branch_taken) begin
                    succPhase = 2'd3;
                end else if ((bus.opcode == OP_OP || bus.opcode == OP_IMM) && bus.shift_busy) begin
                    succRepeat = 1'b1;
                end else begin
                    succEnd = 1'b1;
                end
            end
            default: succEnd = 1'b1;
        endcase
    end

    always_comb begin
        case (bus.opcode)
            OP_STORE, OP_BRANCH, OP_FENCE: rfWren = 1'b0;
            OP_JAL, OP_AUIPC, OP_SYS:      rfWren = (phase_q == 2'd0);
            OP_LOAD:                       rfWren = (phase_q == 2'd3);
            default:                       rfWren = (phase_q == 2'd2);
        endcase
    end

    // Enables are gated by rst_n so they drop the instant reset asserts.
    assign finalPhase = isRun && succEnd;
    assign memRden    = rst_n && (isBoot || finalPhase ||
                        (isRun && bus.opcode == OP_LOAD && phase_q == 2'd2));
    assign memWren    = rst_n && isRun && bus.opcode == OP_STORE && phase_q == 2'd1;
    assign memWait    = (memRden || memWren) && !bus.mem_ready;
    assign complete   = !isHalt && lastBeat && !memWait;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        beat_d      = beat_q;
        firstBeat_d = 1'b0;
        if (!complete && !isHalt && !lastBeat) begin
            beat_d = beat_q + BW'(1);
        end
        case (state_q)
            S_BOOT: begin
                if (complete) begin
                    state_d     = S_RUN;
                    phase_d     = 2'd0;
                    beat_d      = '0;
                    firstBeat_d = 1'b1;
                end
            end
            S_RUN: begin
                if (complete) begin
                    beat_d = '0;
                    if (succHalt) begin
                        state_d = S_HALT;
                        phase_d = 2'd0;
                    end else if (succRepeat) begin
                        phase_d = 2'd2;
                    end else begin
                        phase_d     = succEnd ? endPhase : succPhase;
                        firstBeat_d = 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (bus.resume) begin
                    state_d     = S_RUN;
                    phase_d     = 2'd2;
                    beat_d      = '0;
                    firstBeat_d = 1'b1;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_BOOT;
            phase_q     <= 2'd1;
            beat_q      <= '0;
            firstBeat_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            beat_q      <= beat_d;
            firstBeat_q <= firstBeat_d;
        end
    end

    assign bus.phase      = isHalt ? 2'd0 : phase_q;
    assign bus.beat       = beat_q;
    assign bus.first_beat = firstBeat_q;
    assign bus.last_beat  = lastBeat;
    assign bus.boot       = isBoot;
    assign bus.halted     = isHalt;
    assign bus.stall      = !isHalt && lastBeat && memWait;
    assign bus.rf_wren    = rst_n && isRun && rfWren;
    assign bus.mem_rden   = memRden;
    assign bus.mem_wren   = memWren;
    assign bus.trap       = rst_n && isRun && bus.opcode == OP_SYS && phase_q == 2'd0;
endmodule

// File: tb/tb_phase_seq.sv
// Scoreboard bench for phase_seq: each completed phase (or HALT stay) is
// summarised by the monitor and compared with hand-computed records.
module tb_phase_seq;
    import phase_seq_pkg::*;

    localparam int BW = 2;

    typedef struct packed {
        logic       boot;
        logic       halted;
        logic [1:0] phase;
        logic [7:0] cycles;
        logic [7:0] stalls;
        logic [7:0] rf;
        logic [7:0] rden;
        logic [7:0] wren;
        logic [7:0] trap;
        logic [7:0] first;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rec_t  expQ[$];
    string tagQ[$];
    rec_t  acc, want;
    string tag;
    int    checks = 0;
    int    passes = 0;

    phase_seq_if #(.BW(BW)) bus ();

    phase_seq #(.XLEN(32), .SLICE(8), .HALT_ON_TRAP(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic string fmt(rec_t r);
        return $sformatf("boot=%0d halt=%0d ph=%0d cyc=%0d stall=%0d rf=%0d rd=%0d wr=%0d trap=%0d fb=%0d",
                         r.boot, r.halted, r.phase, r.cycles, r.stalls, r.rf, r.rden, r.wren,
                         r.trap, r.first);
    endfunction

    // Monitor: accumulate per-cycle activity, close a record at each phase end.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc = '0;
        end else begin
            acc.cycles = acc.cycles + 8'd1;
            acc.stalls = acc.stalls + 8'(bus.stall);
            acc.rf     = acc.rf     + 8'(bus.rf_wren);
            acc.rden   = acc.rden   + 8'(bus.mem_rden);
            acc.wren   = acc.wren   + 8'(bus.mem_wren);
            acc.trap   = acc.trap   + 8'(bus.trap);
            acc.first  = acc.first  + 8'(bus.first_beat);
            if (bus.halted ? bus.resume : (bus.last_beat && !bus.stall)) begin
                acc.boot   = bus.boot;
                acc.halted = bus.halted;
                acc.phase  = bus.phase;
                checks++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL unexpected_end: got %s, required none", fmt(acc));
                end else begin
                    want = expQ.pop_front();
                    tag  = tagQ.pop_front();
                    if (acc == want) passes++;
                    else $display("[TB] FAIL %s: got %s, required %s", tag, fmt(acc), fmt(want));
                end
                acc = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input opcode_t op, input logic taken, input logic fwd,
                                 input opcode_t nxt, input logic busy);
        bus.opcode        = op;
        bus.branch_taken  = taken;
        bus.forward_taken = fwd;
        bus.next_opcode   = nxt;
        bus.shift_busy    = busy;
    endtask

    task automatic expectPhase(input string name, input int b, input int h, input int ph,
                               input int cyc, input int st, input int rf, input int rd,
                               input int wr, input int tr, input int fb);
        rec_t r;
        r = '{boot: 1'(b), halted: 1'(h), phase: 2'(ph), cycles: 8'(cyc), stalls: 8'(st),
              rf: 8'(rf), rden: 8'(rd), wren: 8'(wr), trap: 8'(tr), first: 8'(fb)};
        expQ.push_back(r);
        tagQ.push_back(name);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    endtask

    task automatic checkReset(input string when);
        checkOutput({when, "_phase"},      int'(bus.phase),      1);
        checkOutput({when, "_beat"},       int'(bus.beat),       0);
        checkOutput({when, "_first_beat"}, int'(bus.first_beat), 1);
        checkOutput({when, "_last_beat"},  int'(bus.last_beat),  0);
        checkOutput({when, "_boot"},       int'(bus.boot),       1);
        checkOutput({when, "_halted"},     int'(bus.halted),     0);
        checkOutput({when, "_stall"},      int'(bus.stall),      0);
        checkOutput({when, "_rf_wren"},    int'(bus.rf_wren),    0);
        checkOutput({when, "_mem_rden"},   int'(bus.mem_rden),   0);
        checkOutput({when, "_mem_wren"},   int'(bus.mem_wren),   0);
        checkOutput({when, "_trap"},       int'(bus.trap),       0);
    endtask

    initial begin
        applyStimulus(OP_IMM, 1'b0, 1'b0, OP_OP, 1'b0);
        bus.mem_ready = 1'b1;
        bus.resume    = 1'b0;
        runCycles(2);
        checkReset("por");

        //          name          b  h  ph cyc st rf rd wr tr fb
        expectPhase("boot",       1, 0, 1, 4,  0, 0, 4, 0, 0, 1);
        expectPhase("imm_p0",     0, 0, 0, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("imm_p2",     0, 0, 2, 4,  0, 4, 4, 0, 0, 1);
        rst_n = 1'b1;
        runCycles(12);

        // LOAD with three wait cycles at the phase 2 last beat
        applyStimulus(OP_LOAD, 1'b0, 1'b0, OP_OP, 1'b0);
        expectPhase("load_p0",    0, 0, 0, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("load_p1",    0, 0, 1, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("load_p2",    0, 0, 2, 7,  3, 0, 7, 0, 0, 1);
        expectPhase("load_p3",    0, 0, 3, 4,  0, 4, 4, 0, 0, 1);
        runCycles(11);
        bus.mem_ready = 1'b0;
        runCycles(3);
        bus.mem_ready = 1'b1;
        runCycles(5);

        applyStimulus(OP_BRANCH, 1'b1, 1'b0, OP_OP, 1'b0);
        expectPhase("bt_p0",      0, 0, 0, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("bt_p1",      0, 0, 1, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("bt_p2",      0, 0, 2, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("bt_p3",      0, 0, 3, 4,  0, 0, 4, 0, 0, 1);
        runCycles(16);

        // Untaken branch forwarding into an OP that skips phase 0
        applyStimulus(OP_BRANCH, 1'b0, 1'b1, OP_OP, 1'b0);
        expectPhase("bn_p0",      0, 0, 0, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("bn_p1",      0, 0, 1, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("bn_p2",      0, 0, 2, 4,  0, 0, 4, 0, 0, 1);
        expectPhase("fwd_op_p1",  0, 0, 1, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("fwd_op_p2",  0, 0, 2, 4,  0, 4, 4, 0, 0, 1);
        runCycles(12);
        applyStimulus(OP_OP, 1'b0, 1'b0, OP_OP, 1'b0);
        runCycles(7);
        bus.resume = 1'b1;
        runCycles(1);
        bus.resume = 1'b0;

        applyStimulus(OP_IMM, 1'b0, 1'b0, OP_OP, 1'b1);
        expectPhase("shift_p0",   0, 0, 0, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("shift_p2a",  0, 0, 2, 4,  0, 4, 0, 0, 0, 1);
        expectPhase("shift_p2b",  0, 0, 2, 4,  0, 4, 0, 0, 0, 0);
        expectPhase("shift_p2c",  0, 0, 2, 4,  0, 4, 4, 0, 0, 0);
        runCycles(12);
        bus.shift_busy = 1'b0;
        runCycles(4);

        applyStimulus(OP_SYS, 1'b0, 1'b0, OP_OP, 1'b0);
        expectPhase("sys_p0",     0, 0, 0, 4,  0, 4, 0, 0, 4, 1);
        expectPhase("sys_halt",   0, 1, 0, 10, 0, 0, 0, 0, 0, 0);
        expectPhase("sys_p2",     0, 0, 2, 4,  0, 0, 4, 0, 0, 1);
        runCycles(13);
        bus.resume = 1'b1;
        runCycles(1);
        bus.resume = 1'b0;
        runCycles(4);

        applyStimulus(OP_STORE, 1'b0, 1'b0, OP_OP, 1'b0);
        expectPhase("store_p0",   0, 0, 0, 4,  0, 0, 0, 0, 0, 1);
        expectPhase("store_p1",   0, 0, 1, 5,  1, 0, 0, 5, 0, 1);
        expectPhase("store_p3",   0, 0, 3, 4,  0, 0, 4, 0, 0, 1);
        runCycles(7);
        bus.mem_ready = 1'b0;
        runCycles(1);
        bus.mem_ready = 1'b1;
        runCycles(5);

        // Reset dropped in the middle of phase 2, beat 2
        applyStimulus(OP_IMM, 1'b0, 1'b0, OP_OP, 1'b0);
        expectPhase("pre_rst_p0", 0, 0, 0, 4,  0, 0, 0, 0, 0, 1);
        runCycles(6);
        checkOutput("pre_rst_beat", int'(bus.beat), 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("mid");
        runCycles(2);
        expectPhase("reboot",     1, 0, 1, 4,  0, 0, 4, 0, 0, 1);
        expectPhase("reboot_p0",  0, 0, 0, 4,  0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        runCycles(9);

        checkOutput("pending_records", expQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
